// File: rtl/fpga_cfg_pkg.sv
// Shared types and CRC helper for the tinyFPGA configuration-chain loader.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One serial step of CRC-8, MSB-first feedback.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb_s;
        fb_s = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb_s ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte stream handshake carrying the bitstream into the configuration loader.
interface fpga_cfg_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/cfg_crc8.sv
// Serial CRC-8 accumulator with synchronous clear and bit enable.
module cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // CRC register: reset/clear to init, otherwise fold in one bit per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r <= CRC8_INIT;
        end else if (clear) begin
            crc_r <= CRC8_INIT;
        end else if (en) begin
            crc_r <= crc8_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Shifts a byte-streamed bitstream into the fabric configuration chain and releases user mode.
// Optional readback CRC check is enabled by defining CFG_VERIFY_EN.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 128
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    fpga_cfg_loader_if.slave          s_if,
    output logic                      cfg_en,
    output logic                      cfg_bit,
    input  logic                      cfg_sout,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      fabric_run
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    cfg_state_e     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shreg_r;
    logic           s_ready_r;
    logic           cfg_en_r;
    logic           cfg_bit_r;
    logic           busy_r;
    logic           done_r;
    logic           err_r;
    logic           fabric_run_r;

`ifdef CFG_VERIFY_EN
    logic       start_acc_s;
    logic [7:0] wr_crc_s;
    logic [7:0] rd_crc_s;
    logic       mismatch_s;

    assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    // Final readback bit is folded in here so the verdict is ready on the DONE edge.
    assign mismatch_s  = (crc8_step(rd_crc_s, cfg_sout) != wr_crc_s);

    cfg_crc8 u_crc_wr (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_acc_s),
        .en     (state_r == ST_SHIFT),
        .bit_in (cfg_bit_r),
        .crc    (wr_crc_s)
    );

    cfg_crc8 u_crc_rd (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_acc_s),
        .en     (state_r == ST_VERIFY),
        .bit_in (cfg_sout),
        .crc    (rd_crc_s)
    );
`endif

    // Loader sequencer: state, bit bookkeeping and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shreg_r      <= 8'h00;
            s_ready_r    <= 1'b0;
            cfg_en_r     <= 1'b0;
            cfg_bit_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            fabric_run_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_LOAD;
                        cnt_r        <= '0;
                        s_ready_r    <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
                        fabric_run_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (s_if.s_valid) begin
                        state_r   <= ST_SHIFT;
                        s_ready_r <= 1'b0;
                        cfg_en_r  <= 1'b1;
                        cfg_bit_r <= s_if.s_data[7];
                        shreg_r   <= {s_if.s_data[6:0], 1'b0};
                        bit_idx_r <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == LAST_BIT) begin
                        // Chain full: leftover LSBs of the final byte are dropped.
                        cnt_r     <= '0;
                        cfg_bit_r <= 1'b0;
`ifdef CFG_VERIFY_EN
                        state_r   <= ST_VERIFY;
                        cfg_en_r  <= 1'b1;
`else
                        state_r      <= ST_DONE;
                        cfg_en_r     <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        fabric_run_r <= 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (bit_idx_r == 3'd7) begin
                            state_r   <= ST_LOAD;
                            s_ready_r <= 1'b1;
                            cfg_en_r  <= 1'b0;
                            cfg_bit_r <= 1'b0;
                        end else begin
                            cfg_bit_r <= shreg_r[7];
                            shreg_r   <= {shreg_r[6:0], 1'b0};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
`ifdef CFG_VERIFY_EN
                ST_VERIFY: begin
                    if (cnt_r == LAST_BIT) begin
                        state_r      <= ST_DONE;
                        cnt_r        <= '0;
                        cfg_en_r     <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        err_r        <= mismatch_s;
                        fabric_run_r <= ~mismatch_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    s_ready_r    <= 1'b0;
                    cfg_en_r     <= 1'b0;
                    cfg_bit_r    <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                    fabric_run_r <= 1'b0;
                end
            endcase
        end
    end

    // Recirculation must present the tail bit in the same cycle, so it bypasses the register.
    assign cfg_bit     = (state_r == ST_VERIFY) ? cfg_sout : cfg_bit_r;
    assign cfg_en      = cfg_en_r;
    assign s_if.s_ready = s_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign fabric_run  = fabric_run_r;

endmodule
